// File: rtl/seg7_display.sv
// Eight-digit active-low seven-segment driver: captures BCD nibbles on load and
// decodes them with leading-zero blanking, a per-digit blank code and whole-display blink.
module seg7_display #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] digits,
  input  logic        blank_lz,
  input  logic        blink_en,
  output logic [6:0]  HEX7,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX0
);

  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_DIV - 1);
  localparam logic [6:0] DARK = 7'h7F;

  logic [7:0][3:0] shadow;
  logic [CW-1:0]   count;
  logic            phase;
  logic [7:0][6:0] seg_next;
  logic [7:0][6:0] seg_q;
  logic            lead;
  logic [3:0]      nib;
  logic [6:0]      seg;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] r;
    case (v)
      4'h0:    r = 7'h40;
      4'h1:    r = 7'h79;
      4'h2:    r = 7'h24;
      4'h3:    r = 7'h30;
      4'h4:    r = 7'h19;
      4'h5:    r = 7'h12;
      4'h6:    r = 7'h02;
      4'h7:    r = 7'h78;
      4'h8:    r = 7'h00;
      4'h9:    r = 7'h10;
      4'hF:    r = DARK;
      default: r = 7'h3F;
    endcase
    return r;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow <= '1;
    end else if (load) begin
      shadow <= digits;
    end
  end

  // A load restarts the on half-period even while blinking is enabled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      phase <= 1'b1;
    end else if (load || !blink_en) begin
      count <= '0;
      phase <= 1'b1;
    end else if (count == LAST) begin
      count <= '0;
      phase <= ~phase;
    end else begin
      count <= count + 1'b1;
    end
  end

  // Leading status propagates downward from digit 7 and stops at the first significant digit.
  always_comb begin
    lead     = 1'b1;
    nib      = 4'h0;
    seg      = DARK;
    seg_next = '1;
    for (int i = 7; i >= 0; i--) begin
      nib  = shadow[i];
      lead = lead && ((nib == 4'h0) || (nib == 4'hF));
      seg  = decode(nib);
      if (blank_lz && lead && (nib == 4'h0) && (i != 0)) begin
        seg = DARK;
      end
      if (!phase) begin
        seg = DARK;
      end
      seg_next[i] = seg;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      seg_q <= '1;
    end else begin
      seg_q <= seg_next;
    end
  end

  assign HEX7 = seg_q[7];
  assign HEX6 = seg_q[6];
  assign HEX5 = seg_q[5];
  assign HEX4 = seg_q[4];
  assign HEX3 = seg_q[3];
  assign HEX2 = seg_q[2];
  assign HEX1 = seg_q[1];
  assign HEX0 = seg_q[0];

endmodule

// File: tb/tb_seg7_display.sv
// Directed bench for seg7_display: a display-level reference model checked every cycle,
// plus hand-computed expectations for reset, blanking, blink timing and async reset.
module tb_seg7_display;

  localparam int BLINK_DIV = 4;
  localparam logic [55:0] ALL_DARK = {8{7'h7F}};

  logic        clock;
  logic        reset_n;
  logic        load;
  logic [31:0] digits;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0;
  logic [55:0] hex_all;

  int nvec;
  int nbad;

  seg7_display #(.BLINK_DIV(BLINK_DIV)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .load(load),
    .digits(digits),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .HEX7(HEX7),
    .HEX6(HEX6),
    .HEX5(HEX5),
    .HEX4(HEX4),
    .HEX3(HEX3),
    .HEX2(HEX2),
    .HEX1(HEX1),
    .HEX0(HEX0)
  );

  assign hex_all = {HEX7, HEX6, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: the shown display is a pure function of the captured digits,
  // blank_lz and how many enabled cycles have elapsed since the last restart.
  logic [31:0] m_shadow;
  int          m_run;
  logic [55:0] exp_hex;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] tab [16];
    tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h7F};
    return tab[v];
  endfunction

  function automatic logic [55:0] model_display(input logic [31:0] sh, input logic blz,
                                                input int run);
    logic [55:0] r;
    logic        still_leading;
    logic [3:0]  v;
    logic [6:0]  s;
    r = ALL_DARK;
    if (((run / BLINK_DIV) % 2) != 0) return r;
    still_leading = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      v = sh[4*i +: 4];
      if (v != 4'h0 && v != 4'hF) still_leading = 1'b0;
      s = seg_of(v);
      if (blz && still_leading && v == 4'h0 && i != 0) s = 7'h7F;
      r[7*i +: 7] = s;
    end
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_shadow <= '1;
      m_run    <= 0;
      exp_hex  <= ALL_DARK;
    end else begin
      exp_hex <= model_display(m_shadow, blank_lz, m_run);
      if (load) begin
        m_shadow <= digits;
        m_run    <= 0;
      end else if (!blink_en) begin
        m_run <= 0;
      end else begin
        m_run <= m_run + 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [55:0] act, input logic [55:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkDigit(input string name, input int i, input logic [6:0] exp);
    checkOutput(name, {49'b0, hex_all[7*i +: 7]}, {49'b0, exp});
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare against the model.
  task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic blz,
                               input logic be);
    load     = ld;
    digits   = d;
    blank_lz = blz;
    blink_en = be;
    @(posedge clock);
    @(negedge clock);
    checkOutput("model", hex_all, exp_hex);
  endtask

  task automatic asyncReset(input string name);
    load = 1'b0;
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput(name, hex_all, ALL_DARK);
    @(negedge clock);
    @(negedge clock);
    reset_n  = 1'b1;
    blink_en = 1'b0;
  endtask

  task automatic scenarioBlank(input string name);
    applyStimulus(1'b1, 32'h0000_1234, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0000_1234, 1'b1, 1'b0);
    checkOutput({name, "_lz"}, hex_all,
                {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30, 7'h19});
    applyStimulus(1'b0, 32'h0000_1234, 1'b0, 1'b0);
    checkOutput({name, "_nolz"}, hex_all,
                {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19});
  endtask

  initial begin
    nvec     = 0;
    nbad     = 0;
    reset_n  = 1'b0;
    load     = 1'b0;
    digits   = '0;
    blank_lz = 1'b0;
    blink_en = 1'b0;

    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_value", hex_all, ALL_DARK);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    checkOutput("idle_after_reset", hex_all, ALL_DARK);

    scenarioBlank("blank");

    applyStimulus(1'b1, 32'h0000_0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0000_0000, 1'b1, 1'b0);
    checkOutput("all_zero", hex_all, {{7{7'h7F}}, 7'h40});
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("all_blank", hex_all, ALL_DARK);
    applyStimulus(1'b1, 32'h0F0A_0009, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkDigit("mixed_hex6", 6, 7'h7F);
    checkDigit("mixed_hex4", 4, 7'h3F);
    checkDigit("mixed_hex3", 3, 7'h40);
    checkDigit("mixed_hex0", 0, 7'h10);

    applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h2, 1'b0, 1'b0);
    checkDigit("b2b_first", 0, 7'h79);
    applyStimulus(1'b1, 32'h3, 1'b0, 1'b0);
    checkDigit("b2b_second", 0, 7'h24);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkDigit("b2b_third", 0, 7'h30);

    asyncReset("async_reset_on");
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post_reset_dark", hex_all, ALL_DARK);

    applyStimulus(1'b1, 32'h0000_0008, 1'b1, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkDigit("blink_first", 0, (c <= BLINK_DIV) ? 7'h00 : 7'h7F);
    end
    applyStimulus(1'b1, 32'h0000_0008, 1'b1, 1'b1);
    checkDigit("blink_reload_edge", 0, 7'h7F);
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
      checkDigit("blink_restart", 0, (c <= BLINK_DIV) ? 7'h00 : 7'h7F);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkDigit("blink_fall_lag", 0, 7'h7F);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkDigit("blink_fall_on", 0, 7'h00);
    for (int c = 1; c <= 6; c++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkDigit("blink_off_again", 0, 7'h7F);

    asyncReset("async_reset_off");
    for (int c = 0; c < 10; c++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("idle_after_reset2", hex_all, ALL_DARK);
    scenarioBlank("blank_again");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
